// File: rtl/sram_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sram_req_ctrl
//  Description : Initiator-side controller for a registered-input SRAM wrapper.
//                Tracks read latency and returns read data in order behind a
//                credit-limited response FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_req_ctrl #(
   parameter int DATA_WIDTH   = 4,
   parameter int ADDR_WIDTH   = 6,
   parameter int WMASK_WIDTH  = 2,
   parameter int READ_LATENCY = 2,
   parameter int RESP_DEPTH   = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [WMASK_WIDTH-1:0] req_wmask,
   input  logic [ADDR_WIDTH-1:0]  req_addr,
   input  logic [DATA_WIDTH-1:0]  req_wdata,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [DATA_WIDTH-1:0]  resp_rdata,
   output logic                   sram_we,
   output logic [WMASK_WIDTH-1:0] sram_wmask,
   output logic [ADDR_WIDTH-1:0]  sram_addr,
   output logic [DATA_WIDTH-1:0]  sram_din,
   input  logic [DATA_WIDTH-1:0]  sram_dout,
   output logic                   busy
);

   localparam int c_PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int c_CNT_W = $clog2(RESP_DEPTH + 1);
   localparam int c_OUT_W = $clog2(RESP_DEPTH + READ_LATENCY + 1);
   localparam logic [c_OUT_W-1:0] c_DEPTH_O  = c_OUT_W'(RESP_DEPTH);
   localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(RESP_DEPTH - 1);

   logic [READ_LATENCY-1:0] r_rd_pipe;
   logic [DATA_WIDTH-1:0]   r_mem [RESP_DEPTH];
   logic [c_PTR_W-1:0]      r_wr_ptr;
   logic [c_PTR_W-1:0]      r_rd_ptr;
   logic [c_CNT_W-1:0]      r_fifo_count;

   logic [c_OUT_W-1:0]      w_pipe_cnt;
   logic [c_OUT_W-1:0]      w_outstanding;
   logic                    w_req_fire;
   logic                    w_rd_fire;
   logic                    w_push;
   logic                    w_pop;

   function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
      return (p == c_LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      w_pipe_cnt = '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
         w_pipe_cnt = w_pipe_cnt + c_OUT_W'(r_rd_pipe[i]);
      end
   end

   // Every read in flight or buffered holds a FIFO slot, so a push can never overflow.
   assign w_outstanding = w_pipe_cnt + c_OUT_W'(r_fifo_count);
   assign req_ready     = ~reset & (w_outstanding < c_DEPTH_O);
   assign w_req_fire    = req_valid & req_ready;
   assign w_rd_fire     = w_req_fire & ~req_we;
   assign w_push        = r_rd_pipe[READ_LATENCY-1];
   assign w_pop         = resp_valid & resp_ready;

   assign sram_addr  = req_addr;
   assign sram_din   = req_wdata;
   assign sram_wmask = req_we ? req_wmask : '0;
   assign sram_we    = w_req_fire & req_we;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rd_pipe <= '0;
      end else begin
         r_rd_pipe[0] <= w_rd_fire;
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_rd_pipe[i] <= r_rd_pipe[i-1];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_fifo_count <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         r_fifo_count <= r_fifo_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr] <= sram_dout;
   end

   assign resp_valid = (r_fifo_count != '0);
   assign resp_rdata = r_mem[r_rd_ptr];
   assign busy       = (|r_rd_pipe) | (r_fifo_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_sram_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_req_ctrl
//  Description : Directed and random bench for sram_req_ctrl with a
//                registered-input SRAM wrapper model and a reference memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_req_ctrl;

   localparam int c_DW  = 4;
   localparam int c_AW  = 6;
   localparam int c_MW  = 2;
   localparam int c_LAT = 2;
   localparam int c_DEP = 4;

   logic            clock = 1'b0;
   logic            reset;
   logic            req_valid, req_ready, req_we;
   logic [c_MW-1:0] req_wmask;
   logic [c_AW-1:0] req_addr;
   logic [c_DW-1:0] req_wdata;
   logic            resp_valid, resp_ready;
   logic [c_DW-1:0] resp_rdata;
   logic            sram_we;
   logic [c_MW-1:0] sram_wmask;
   logic [c_AW-1:0] sram_addr;
   logic [c_DW-1:0] sram_din, sram_dout;
   logic            busy;

   always #5 clock = ~clock;

   sram_req_ctrl #(
      .DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW), .WMASK_WIDTH(c_MW),
      .READ_LATENCY(c_LAT), .RESP_DEPTH(c_DEP)
   ) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
      .sram_din(sram_din), .sram_dout(sram_dout), .busy(busy)
   );

   function automatic logic [c_DW-1:0] merge(input logic [c_DW-1:0] old_v,
                                             input logic [c_DW-1:0] new_v,
                                             input logic [c_MW-1:0] mask);
      logic [c_DW-1:0] r;
      r = old_v;
      for (int b = 0; b < c_DW; b++) if (mask[b / (c_DW / c_MW)]) r[b] = new_v[b];
      return r;
   endfunction

   // Wrapper model: input flops, then the macro one edge later.
   logic [c_DW-1:0] sram_arr [1 << c_AW];
   logic            w_we_q;
   logic [c_MW-1:0] w_mask_q;
   logic [c_AW-1:0] w_addr_q;
   logic [c_DW-1:0] w_din_q;
   always @(posedge clock) begin
      if (w_we_q) sram_arr[w_addr_q] <= merge(sram_arr[w_addr_q], w_din_q, w_mask_q);
      else        sram_dout <= sram_arr[w_addr_q];
      w_we_q   <= sram_we;
      w_mask_q <= sram_wmask;
      w_addr_q <= sram_addr;
      w_din_q  <= sram_din;
   end

   // Reference model: memory image at acceptance time plus in-order expected reads.
   logic [c_DW-1:0] ref_mem [1 << c_AW];
   logic [c_DW-1:0] exp_q [$];
   int              due_q [$];
   int              cyc = 0;
   int              n_vec = 0;
   int              n_err = 0;
   int              dut_fires = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      logic exp_rdy, fire, exp_vld;
      @(negedge clock);
      if (reset) begin
         exp_q.delete();
         due_q.delete();
      end
      exp_rdy = !reset && (exp_q.size() < c_DEP);
      chk("req_ready", req_ready, exp_rdy);
      fire = req_valid && exp_rdy;
      if (req_valid && req_ready) dut_fires++;
      chk("sram_we", sram_we, fire && req_we);
      if (fire) begin
         chk("sram_addr", sram_addr, req_addr);
         if (req_we) chk("sram_din", sram_din, req_wdata);
         chk("sram_wmask", sram_wmask, req_we ? req_wmask : '0);
      end
      exp_vld = !reset && exp_q.size() > 0 && due_q[0] <= cyc;
      chk("resp_valid", resp_valid, exp_vld);
      if (exp_vld) chk("resp_rdata", resp_rdata, exp_q[0]);
      chk("busy", busy, !reset && exp_q.size() != 0);
      chk("fifo_overflow", dut.r_fifo_count > c_DEP, 1'b0);
      if (exp_vld && resp_ready) begin
         void'(exp_q.pop_front());
         void'(due_q.pop_front());
      end
      if (fire && req_we) ref_mem[req_addr] = merge(ref_mem[req_addr], req_wdata, req_wmask);
      if (fire && !req_we) begin
         exp_q.push_back(ref_mem[req_addr]);
         due_q.push_back(cyc + 1 + c_LAT);
      end
      @(posedge clock);
      cyc++;
      #1;
   endtask

   task automatic drive(input logic v, input logic we, input logic [c_MW-1:0] m,
                        input logic [c_AW-1:0] a, input logic [c_DW-1:0] d);
      req_valid = v; req_we = we; req_wmask = m; req_addr = a; req_wdata = d;
   endtask

   task automatic issue(input logic we, input logic [c_MW-1:0] m,
                        input logic [c_AW-1:0] a, input logic [c_DW-1:0] d);
      int t;
      drive(1'b1, we, m, a, d);
      t = 0;
      while (!req_ready && t < 50) begin step(); t++; end
      if (t >= 50) chk("issue_timeout", 1'b1, 1'b0);
      step();
      drive(1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 100) begin step(); t++; end
      if (t >= 100) chk("drain_timeout", 1'b1, 1'b0);
      step();
   endtask

   initial begin
      for (int i = 0; i < (1 << c_AW); i++) begin
         sram_arr[i] = '0;
         ref_mem[i]  = '0;
      end
      w_we_q = 1'b0; w_mask_q = '0; w_addr_q = '0; w_din_q = '0; sram_dout = '0;
      reset = 1'b1;
      resp_ready = 1'b1;
      drive(1'b0, 1'b0, '0, '0, '0);
      repeat (3) step();
      drive(1'b1, 1'b0, '0, 6'd1, '0);
      step();
      drive(1'b0, 1'b0, '0, '0, '0);
      reset = 1'b0;
      step();

      // Write then immediate read of the same address
      issue(1'b1, 2'b11, 6'd5, 4'hA);
      issue(1'b0, 2'b00, 6'd5, 4'h0);
      drain();

      // Masked write merges only lane 0
      issue(1'b1, 2'b11, 6'd9, 4'h0);
      issue(1'b1, 2'b01, 6'd9, 4'hF);
      issue(1'b0, 2'b00, 6'd9, 4'h0);
      drain();

      // Preload and back-to-back reads
      for (int a = 0; a < 8; a++) issue(1'b1, 2'b11, 6'(a), 4'(a));
      for (int a = 0; a < 8; a++) begin
         drive(1'b1, 1'b0, 2'b00, 6'(a), 4'h0);
         step();
      end
      drive(1'b0, 1'b0, '0, '0, '0);
      drain();

      // Backpressure: only RESP_DEPTH reads accepted, writes stall too
      resp_ready = 1'b0;
      dut_fires  = 0;
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 1'b0, 2'b00, 6'(dut_fires), 4'h0);
         step();
      end
      chk("bp_accepted", dut_fires, c_DEP);
      drive(1'b1, 1'b1, 2'b11, 6'd20, 4'h7);
      repeat (2) step();
      resp_ready = 1'b1;
      issue(1'b0, 2'b00, 6'd4, 4'h0);
      issue(1'b0, 2'b00, 6'd5, 4'h0);
      issue(1'b1, 2'b11, 6'd20, 4'h7);
      drain();

      // Reset with reads in flight drops them
      issue(1'b0, 2'b00, 6'd2, 4'h0);
      issue(1'b0, 2'b00, 6'd3, 4'h0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (4) step();
      issue(1'b0, 2'b00, 6'd6, 4'h0);
      drain();

      // Random stress
      for (int k = 0; k < 600; k++) begin
         resp_ready = ($urandom_range(0, 9) < 7);
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
               2'($urandom), 6'($urandom_range(0, 15)), 4'($urandom));
         step();
      end
      drive(1'b0, 1'b0, '0, '0, '0);
      resp_ready = 1'b1;
      drain();
      chk("quiescent_busy", busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
